// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and writeback priority encodings.
// The register file itself imports this package as well.
package regfile_wb_arbiter_pkg;

  localparam int REG_COUNT = 32;
  localparam int REG_W     = 32;

  typedef enum logic {
    PRIO_MEM = 1'b0,
    PRIO_ALU = 1'b1
  } prio_e;

  // Bit positions of each writeback source in the arbiter req/gnt vectors.
  localparam int GNT_MEM = 0;
  localparam int GNT_ALU = 1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter; the priority bit flips to the loser after
// every grant and holds when nothing is granted.
module rr_arbiter2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       aresetn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  prio_e prio_q;

  // Grants are forced low while reset is held so no handshake can complete.
  always_comb begin
    gnt = 2'b00;
    if (aresetn) begin
      if (req[GNT_MEM] && req[GNT_ALU]) begin
        gnt[GNT_MEM] = (prio_q == PRIO_MEM);
        gnt[GNT_ALU] = (prio_q == PRIO_ALU);
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      prio_q <= PRIO_MEM;
    end else if (gnt[GNT_MEM]) begin
      prio_q <= PRIO_ALU;
    end else if (gnt[GNT_ALU]) begin
      prio_q <= PRIO_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port between ALU and load writeback, registers
// the winning write for one cycle and bypasses it onto both read ports.
module regfile_wb_arbiter #(
  parameter int REG_COUNT = regfile_wb_arbiter_pkg::REG_COUNT,
  parameter int REG_W     = regfile_wb_arbiter_pkg::REG_W,
  localparam int REG_IDX_W = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [REG_IDX_W-1:0] alu_reg,
  input  logic [REG_W-1:0]     alu_data,
  input  logic                 mem_valid,
  output logic                 mem_ready,
  input  logic [REG_IDX_W-1:0] mem_reg,
  input  logic [REG_W-1:0]     mem_data,
  output logic                 rf_wr_en,
  output logic [REG_IDX_W-1:0] rf_wr_reg,
  output logic [REG_W-1:0]     rf_wr_data,
  input  logic [REG_IDX_W-1:0] rd_reg_a,
  input  logic [REG_IDX_W-1:0] rd_reg_b,
  input  logic [REG_W-1:0]     rf_rd_data_a,
  input  logic [REG_W-1:0]     rf_rd_data_b,
  output logic [REG_W-1:0]     rd_data_a,
  output logic [REG_W-1:0]     rd_data_b
);

  import regfile_wb_arbiter_pkg::*;

  logic [1:0]           req;
  logic [1:0]           gnt;
  logic [REG_IDX_W-1:0] win_reg;
  logic [REG_W-1:0]     win_data;

  assign req[GNT_MEM] = mem_valid;
  assign req[GNT_ALU] = alu_valid;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .aresetn (aresetn),
    .req     (req),
    .gnt     (gnt)
  );

  assign mem_ready = gnt[GNT_MEM];
  assign alu_ready = gnt[GNT_ALU];
  assign win_reg   = gnt[GNT_ALU] ? alu_reg  : mem_reg;
  assign win_data  = gnt[GNT_ALU] ? alu_data : mem_data;

  // Writes to x0 still complete the handshake but never reach the port.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rf_wr_en   <= 1'b0;
      rf_wr_reg  <= '0;
      rf_wr_data <= '0;
    end else if ((gnt != 2'b00) && (win_reg != '0)) begin
      rf_wr_en   <= 1'b1;
      rf_wr_reg  <= win_reg;
      rf_wr_data <= win_data;
    end else begin
      rf_wr_en   <= 1'b0;
      rf_wr_reg  <= '0;
      rf_wr_data <= '0;
    end
  end

  assign rd_data_a = (rd_reg_a == '0) ? '0 :
                     (rf_wr_en && rf_wr_reg == rd_reg_a) ? rf_wr_data : rf_rd_data_a;
  assign rd_data_b = (rd_reg_b == '0) ? '0 :
                     (rf_wr_en && rf_wr_reg == rd_reg_b) ? rf_wr_data : rf_rd_data_b;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic checked
// every cycle against an architectural register model kept in the bench.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        alu_valid, mem_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_reg;
  logic [31:0] rf_wr_data;
  logic [4:0]  rd_reg_a, rd_reg_b;
  logic [31:0] rf_rd_data_a, rf_rd_data_b;
  logic [31:0] rd_data_a, rd_data_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_reg      (alu_reg),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_reg      (mem_reg),
    .mem_data     (mem_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_reg    (rf_wr_reg),
    .rf_wr_data   (rf_wr_data),
    .rd_reg_a     (rd_reg_a),
    .rd_reg_b     (rd_reg_b),
    .rf_rd_data_a (rf_rd_data_a),
    .rf_rd_data_b (rf_rd_data_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b)
  );

  // Environment register file: unwritten entries hold an index-derived value.
  function automatic logic [31:0] seedVal(input logic [4:0] idx);
    seedVal = ({27'd0, idx} * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  logic        tbInit = 1'b1;
  logic [31:0] envRf [32];
  logic [31:0] envWritten;

  always @(posedge clk) begin
    if (tbInit) envWritten <= '0;
    else if (rf_wr_en) begin
      envRf[rf_wr_reg]      <= rf_wr_data;
      envWritten[rf_wr_reg] <= 1'b1;
    end
  end

  always_comb begin
    rf_rd_data_a = envWritten[rd_reg_a] ? envRf[rd_reg_a] : seedVal(rd_reg_a);
    rf_rd_data_b = envWritten[rd_reg_b] ? envRf[rd_reg_b] : seedVal(rd_reg_b);
  end

  // Architectural model: golden holds what decode must see, updated at the
  // accepting edge; undo remembers the in-flight write so reset can drop it.
  logic [31:0] golden [32];
  logic        lastAlu;
  logic        expAluGnt, expMemGnt;
  logic        expWrEn;
  logic [4:0]  expWrReg;
  logic [31:0] expWrData;
  logic        undoValid;
  logic [4:0]  undoReg;
  logic [31:0] undoData;

  function automatic logic [31:0] expRead(input logic [4:0] idx);
    expRead = (idx == 5'd0) ? 32'd0 : golden[idx];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCycle();
    @(negedge clk);
    expAluGnt = 1'b0;
    expMemGnt = 1'b0;
    if (aresetn) begin
      if (alu_valid && mem_valid) begin
        expMemGnt = lastAlu;
        expAluGnt = !lastAlu;
      end else begin
        expAluGnt = alu_valid;
        expMemGnt = mem_valid;
      end
    end
    checkOutput("alu_ready", {31'd0, alu_ready}, {31'd0, expAluGnt});
    checkOutput("mem_ready", {31'd0, mem_ready}, {31'd0, expMemGnt});
    checkOutput("rf_wr_en", {31'd0, rf_wr_en}, {31'd0, expWrEn});
    checkOutput("rf_wr_reg", {27'd0, rf_wr_reg}, {27'd0, expWrReg});
    checkOutput("rf_wr_data", rf_wr_data, expWrData);
    checkOutput("rd_data_a", rd_data_a, expRead(rd_reg_a));
    checkOutput("rd_data_b", rd_data_b, expRead(rd_reg_b));
  endtask

  task automatic advance();
    logic [4:0]  wReg;
    logic [31:0] wData;
    @(posedge clk);
    #1;
    if (expAluGnt || expMemGnt) begin
      wReg    = expAluGnt ? alu_reg : mem_reg;
      wData   = expAluGnt ? alu_data : mem_data;
      lastAlu = expAluGnt;
      if (wReg != 5'd0) begin
        undoValid    = 1'b1;
        undoReg      = wReg;
        undoData     = golden[wReg];
        golden[wReg] = wData;
        expWrEn      = 1'b1;
        expWrReg     = wReg;
        expWrData    = wData;
      end else begin
        undoValid = 1'b0;
        expWrEn   = 1'b0;
        expWrReg  = 5'd0;
        expWrData = 32'd0;
      end
      if (expAluGnt) alu_valid = 1'b0;
      else mem_valid = 1'b0;
    end else begin
      undoValid = 1'b0;
      expWrEn   = 1'b0;
      expWrReg  = 5'd0;
      expWrData = 32'd0;
    end
    expAluGnt = 1'b0;
    expMemGnt = 1'b0;
  endtask

  task automatic applyStimulus(input logic useAlu, input logic [4:0] idx, input logic [31:0] data);
    if (useAlu) begin
      alu_valid = 1'b1;
      alu_reg   = idx;
      alu_data  = data;
    end else begin
      mem_valid = 1'b1;
      mem_reg   = idx;
      mem_data  = data;
    end
  endtask

  task automatic assertReset();
    aresetn = 1'b0;
    #1;
    if (undoValid) golden[undoReg] = undoData;
    undoValid = 1'b0;
    expWrEn   = 1'b0;
    expWrReg  = 5'd0;
    expWrData = 32'd0;
    lastAlu   = 1'b1;
    expAluGnt = 1'b0;
    expMemGnt = 1'b0;
    checkOutput("reset_wr_en_async", {31'd0, rf_wr_en}, 32'd0);
  endtask

  initial begin
    aresetn   = 1'b0;
    lastAlu   = 1'b1;
    undoValid = 1'b0;
    undoReg   = 5'd0;
    undoData  = 32'd0;
    expWrEn   = 1'b0;
    expWrReg  = 5'd0;
    expWrData = 32'd0;
    expAluGnt = 1'b0;
    expMemGnt = 1'b0;
    for (int i = 0; i < 32; i++) golden[i] = seedVal(i[4:0]);
    rd_reg_a = 5'd1;
    rd_reg_b = 5'd2;
    applyStimulus(1'b1, 5'd9, 32'hAAAA_0001);
    applyStimulus(1'b0, 5'd10, 32'hBBBB_0002);

    // Reset held with both sources requesting.
    repeat (2) begin
      checkCycle();
      checkOutput("lit_reset_alu_ready", {31'd0, alu_ready}, 32'd0);
      checkOutput("lit_reset_mem_ready", {31'd0, mem_ready}, 32'd0);
      checkOutput("lit_reset_wr_data", rf_wr_data, 32'd0);
      advance();
    end
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    aresetn   = 1'b1;
    tbInit    = 1'b0;

    // Single ALU write with bypass, then register-file sourced read.
    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF);
    rd_reg_a = 5'd5;
    checkCycle();
    checkOutput("lit_single_alu_ready", {31'd0, alu_ready}, 32'd1);
    advance();
    checkCycle();
    checkOutput("lit_single_wr_en", {31'd0, rf_wr_en}, 32'd1);
    checkOutput("lit_single_wr_reg", {27'd0, rf_wr_reg}, 32'd5);
    checkOutput("lit_single_bypass", rd_data_a, 32'hDEAD_BEEF);
    advance();
    checkCycle();
    checkOutput("lit_single_rf_read", rd_data_a, 32'hDEAD_BEEF);
    advance();

    // Contention: mem first, alu next, writes land x3 then x4.
    applyStimulus(1'b0, 5'd3, 32'h11);
    applyStimulus(1'b1, 5'd4, 32'h22);
    rd_reg_b = 5'd4;
    checkCycle();
    checkOutput("lit_cont_mem_ready", {31'd0, mem_ready}, 32'd1);
    checkOutput("lit_cont_alu_wait", {31'd0, alu_ready}, 32'd0);
    advance();
    checkCycle();
    checkOutput("lit_cont_alu_ready", {31'd0, alu_ready}, 32'd1);
    checkOutput("lit_cont_wr_x3", {27'd0, rf_wr_reg}, 32'd3);
    advance();
    checkCycle();
    checkOutput("lit_cont_wr_x4", {27'd0, rf_wr_reg}, 32'd4);
    checkOutput("lit_cont_data_x4", rf_wr_data, 32'h22);
    advance();

    // Sustained contention: strict MEM/ALU alternation.
    for (int c = 0; c < 4; c++) begin
      if (!alu_valid) applyStimulus(1'b1, 5'd6, 32'h600 + c);
      if (!mem_valid) applyStimulus(1'b0, 5'd7, 32'h700 + c);
      checkCycle();
      checkOutput("lit_sustain_mem_grant", {31'd0, mem_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      if (c > 0) checkOutput("lit_sustain_busy", {31'd0, rf_wr_en}, 32'd1);
      advance();
    end
    checkCycle();
    advance();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    checkCycle();
    advance();

    // Write to x0 is accepted and dropped.
    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF);
    rd_reg_b = 5'd0;
    checkCycle();
    checkOutput("lit_x0_alu_ready", {31'd0, alu_ready}, 32'd1);
    advance();
    checkCycle();
    checkOutput("lit_x0_wr_en", {31'd0, rf_wr_en}, 32'd0);
    checkOutput("lit_x0_rd_b", rd_data_b, 32'd0);
    advance();

    // Reset while a write is in flight; mem wins first after release.
    applyStimulus(1'b1, 5'd7, 32'h0000_0077);
    rd_reg_a = 5'd7;
    checkCycle();
    advance();
    checkCycle();
    checkOutput("lit_midop_wr_en", {31'd0, rf_wr_en}, 32'd1);
    assertReset();
    applyStimulus(1'b1, 5'd8, 32'h88);
    applyStimulus(1'b0, 5'd9, 32'h99);
    advance();
    checkCycle();
    checkOutput("lit_midop_hold_ready", {30'd0, alu_ready, mem_ready}, 32'd0);
    advance();
    aresetn = 1'b1;
    checkCycle();
    checkOutput("lit_midop_mem_first", {31'd0, mem_ready}, 32'd1);
    advance();

    // Random traffic with occasional mid-operation resets.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!alu_valid && $urandom_range(0, 99) < 60)
        applyStimulus(1'b1, ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)), $urandom);
      if (!mem_valid && $urandom_range(0, 99) < 60)
        applyStimulus(1'b0, ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7)), $urandom);
      rd_reg_a = 5'($urandom_range(0, 7));
      rd_reg_b = 5'($urandom_range(0, 7));
      if (aresetn && $urandom_range(0, 299) == 0) assertReset();
      else if (!aresetn && $urandom_range(0, 2) == 0) aresetn = 1'b1;
      checkCycle();
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
